// File: rtl/mul_issue_stage.sv
// mul_issue_stage: two-register RV32M multiply issue pipeline.
// S1 holds decoded operands for an external combinational multiplier,
// S2 registers the returned product for writeback.
//
// Ports:
//   clk, reset             rising-edge clock, sync active-high reset
//   in_valid/in_ready      upstream handshake
//   funct3, rs1, rs2, rd   instruction fields and operand values
//   M, Q                   signed operand views to the multiplier
//   UM, UQ                 unsigned operand views to the multiplier
//   mulCode                multiply type (MULC/MULHC/MULHUC/MULHSUC)
//   mulResult              combinational product from the multiplier
//   out_valid/out_ready    writeback handshake
//   out_result, out_rd     registered result and destination
//   out_illegal            funct3 was 1xx (not a multiply)
//
// Optional build macro: MUL_RD0_DROP_EN
//   When defined, rd==0 instructions pass through S1 but are discarded
//   there instead of loading S2.

`ifndef MULC
`define MULC    2'b00
`endif
`ifndef MULHC
`define MULHC   2'b01
`endif
`ifndef MULHUC
`define MULHUC  2'b10
`endif
`ifndef MULHSUC
`define MULHSUC 2'b11
`endif

module mul_issue_stage #(
   parameter int dataW = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [dataW-1:0] rs1,
   input  logic [dataW-1:0] rs2,
   input  logic [4:0]       rd,
   output logic [dataW-1:0] M,
   output logic [dataW-1:0] Q,
   output logic [dataW-1:0] UM,
   output logic [dataW-1:0] UQ,
   output logic [1:0]       mulCode,
   input  logic [dataW-1:0] mulResult,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [dataW-1:0] out_result,
   output logic [4:0]       out_rd,
   output logic             out_illegal
);

   // S1: operand/decode register
   logic             s1_v_q,   s1_v_d;
   logic [4:0]       s1_rd_q,  s1_rd_d;
   logic             s1_ill_q, s1_ill_d;
   logic [dataW-1:0] m_q,  m_d;
   logic [dataW-1:0] q_q,  q_d;
   logic [dataW-1:0] um_q, um_d;
   logic [dataW-1:0] uq_q, uq_d;
   logic [1:0]       code_q, code_d;

   // S2: result register
   logic             s2_v_q,   s2_v_d;
   logic [dataW-1:0] s2_res_q, s2_res_d;
   logic [4:0]       s2_rd_q,  s2_rd_d;
   logic             s2_ill_q, s2_ill_d;

   // handshake terms
   logic s1_adv;
   logic s1_load;
   logic s1_keep;
   logic s2_load;

   // S1 leaves when S2 is free or draining this cycle
   assign s1_adv  = s1_v_q && (!s2_v_q || out_ready);
   // Depends only on registered state and out_ready
   assign in_ready = !s1_v_q || s1_adv;
   assign s1_load  = in_valid && in_ready;

`ifdef MUL_RD0_DROP_EN
   assign s1_keep = (s1_rd_q != 5'd0);
`else
   assign s1_keep = 1'b1;
`endif

   // A dropped instruction still vacates S1 but never reaches S2
   assign s2_load = s1_adv && s1_keep;

   // S1 next state and operand decode
   always_comb begin
      s1_v_d   = s1_v_q;
      s1_rd_d  = s1_rd_q;
      s1_ill_d = s1_ill_q;
      m_d      = m_q;
      q_d      = q_q;
      um_d     = um_q;
      uq_d     = uq_q;
      code_d   = code_q;

      if (s1_load) begin
         s1_v_d   = 1'b1;
         s1_rd_d  = rd;
         s1_ill_d = funct3[2];
         m_d      = rs1;
         um_d     = rs1;
         q_d      = rs2;
         uq_d     = rs2;
         code_d   = `MULC;
         unique case (1'b1)
            funct3[2]: begin
               code_d = `MULC;
            end
            (funct3 == 3'b000): begin
               code_d = `MULC;
            end
            (funct3 == 3'b001): begin
               code_d = `MULHC;
            end
            (funct3 == 3'b010): begin
               // rs1 signed x rs2 unsigned: signed side on M/Q,
               // unsigned side on UM/UQ
               code_d = `MULHSUC;
               m_d    = rs1;
               q_d    = rs1;
               um_d   = rs2;
               uq_d   = rs2;
            end
            (funct3 == 3'b011): begin
               code_d = `MULHUC;
            end
            default: begin
               code_d = `MULC;
            end
         endcase
      end else if (s1_adv) begin
         // operands hold their last values while S1 is empty
         s1_v_d = 1'b0;
      end
   end

   // S2 next state
   always_comb begin
      s2_v_d   = s2_v_q;
      s2_res_d = s2_res_q;
      s2_rd_d  = s2_rd_q;
      s2_ill_d = s2_ill_q;

      if (s2_load) begin
         s2_v_d   = 1'b1;
         s2_res_d = s1_ill_q ? '0 : mulResult;
         s2_rd_d  = s1_rd_q;
         s2_ill_d = s1_ill_q;
      end else if (out_ready) begin
         s2_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v_q   <= 1'b0;
         s1_rd_q  <= '0;
         s1_ill_q <= 1'b0;
         m_q      <= '0;
         q_q      <= '0;
         um_q     <= '0;
         uq_q     <= '0;
         code_q   <= `MULC;
         s2_v_q   <= 1'b0;
         s2_res_q <= '0;
         s2_rd_q  <= '0;
         s2_ill_q <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         s1_rd_q  <= s1_rd_d;
         s1_ill_q <= s1_ill_d;
         m_q      <= m_d;
         q_q      <= q_d;
         um_q     <= um_d;
         uq_q     <= uq_d;
         code_q   <= code_d;
         s2_v_q   <= s2_v_d;
         s2_res_q <= s2_res_d;
         s2_rd_q  <= s2_rd_d;
         s2_ill_q <= s2_ill_d;
      end
   end

   assign M           = m_q;
   assign Q           = q_q;
   assign UM          = um_q;
   assign UQ          = uq_q;
   assign mulCode     = code_q;
   assign out_valid   = s2_v_q;
   assign out_result  = s2_res_q;
   assign out_rd      = s2_rd_q;
   assign out_illegal = s2_ill_q;

endmodule

// File: doc/mul_issue_stage.md
MUL_ISSUE_STAGE -- requirements
Module: mul_issue_stage

Interface
REQ-001 Parameter: dataW, default 32, operand/result width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 funct3  input  3  RV32M funct3 field.
REQ-008 rs1, rs2  input  dataW  source operand values.
REQ-009 rd  input  5  destination register index.
REQ-010 M, Q  output  dataW  signed operand views to the multiplier.
REQ-011 UM, UQ  output  dataW  unsigned operand views to the multiplier.
REQ-012 mulCode  output  2  multiply type, encoded with the `MULC/`MULHC/`MULHUC/`MULHSUC macros of mul_codes.sv.
REQ-013 mulResult  input  dataW  combinational result returned by the multiplier.
REQ-014 out_valid  output  1  result valid to writeback.
REQ-015 out_ready  input  1  writeback accepts the result.
REQ-016 out_result  output  dataW  registered result.
REQ-017 out_rd  output  5  destination index of out_result.
REQ-018 out_illegal  output  1  funct3 was not a multiply (1xx).

Function
REQ-019 Two-register pipeline: S1 (operand/decode register) and S2 (result register); multiplier sits combinationally between S1 and S2.
REQ-020 Transfer on in_valid && in_ready; out transfer on out_valid && out_ready.
REQ-021 Latency: accepted instruction appears on out_valid exactly 2 cycles later when out_ready is held high.
REQ-022 Throughput: one instruction per cycle with out_ready high; no bubbles inserted.
REQ-023 S2 loads when S1 valid and (S2 empty or out_ready); S1 loads when in_valid and (S1 empty or S1 advancing).
REQ-024 in_ready = !S1_valid || S1 advancing this cycle; computed from registered state and out_ready only, never from in_valid.
REQ-025 Decode funct3: 000 -> `MULC, 001 -> `MULHC, 010 -> `MULHSUC, 011 -> `MULHUC.
REQ-026 Operand routing for 000/001/011: M=UM=S1.rs1, Q=UQ=S1.rs2.
REQ-027 Operand routing for 010 (rs1 signed x rs2 unsigned): UM=S1.rs2, Q=S1.rs1, M=S1.rs1, UQ=S1.rs2.
REQ-028 funct3 1xx: accepted, out_illegal=1, out_result=0, mulCode=`MULC.
REQ-029 S2 captures mulResult, rd and illegal flag from S1 in the same edge.
REQ-030 Backpressure: with out_ready low and S2 full, S2 outputs held stable; S1 fills then in_ready drops; no data lost or duplicated.
REQ-031 Simultaneous out drain and in accept when full: both occur in the same cycle.
REQ-032 When S1 is empty, M/Q/UM/UQ/mulCode are held at their last values (no toggling).

Reset
REQ-033 On reset: S1_valid=0, S2_valid=0, out_valid=0, out_result=0, out_rd=0, out_illegal=0, operand registers=0, mulCode=`MULC.
REQ-034 in_ready=1 in the first cycle after reset deasserts.
REQ-035 Reset mid-operation discards all in-flight instructions; none appear on out_valid afterwards.

Configuration
REQ-036 Macro MUL_RD0_DROP_EN: when defined, instructions with rd==0 (legal or illegal) are accepted and consume S1 but never load S2 nor raise out_valid.
REQ-037 Without MUL_RD0_DROP_EN, rd==0 instructions are processed and output like any other.

Verification
REQ-038 Reset then funct3=000, rs1=7, rs2=-3, out_ready=1 -> out_valid 2 cycles later, out_result=0xFFFFFFEB, out_illegal=0.
REQ-039 funct3=001, rs1=0x80000000, rs2=0x80000000 -> out_result=0x40000000; funct3=011, rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-040 funct3=010, rs1=-1, rs2=0xFFFFFFFF -> out_result=0xFFFFFFFF; funct3=100 -> out_result=0, out_illegal=1.
REQ-041 Back-to-back 3 instructions, out_ready low 4 cycles -> in_ready low after 2 accepted, outputs stable, all 3 emerge in order once out_ready=1.
REQ-042 Reset asserted with S1 and S2 full -> out_valid=0 next cycle, no stale result emitted.
REQ-043 With MUL_RD0_DROP_EN: rd=0 then rd=5 -> only rd=5 result appears; without it both appear.
